rtr_out_port_arb: RTL and testbench
===================================

Name: rtr_out_port_arb

Overview:
- Per-output-port switch allocator for the 5-port, 2-VC mesh router; one instance per output port.
- Each cycle it picks at most one input flit for its output link.
- A downstream VC stays locked to one input from head flit to tail flit (wormhole), and the allocator honours per-VC downstream readiness.
- It drives the crossbar select and output-valid flops, and reports VC lock state upstream.

Parameters:
- NPORT, 5, number of input ports competing for this output.
- NVC, 2, number of virtual channels on the output link.
- SELW, 3, width of the encoded crossbar select; must be at least clog2(NPORT).

Ports:
- clk  in  1  router clock.
- rst_  in  1  reset; synchronous, active-high (asserted = 1).
- req  in  NPORT  input i has a flit routed to this output.
- req_vc  in  NPORT  VC of input i's flit (NVC=2: one bit per input).
- req_head  in  NPORT  input i's flit is a head flit.
- req_tail  in  NPORT  input i's flit is a tail flit (head and tail both set = single-flit packet).
- vc_rdy  in  NVC  downstream VC v can accept a flit this cycle (from iack).
- gnt  out  NPORT  one-hot combinational grant; the input dequeues its flit when set.
- gnt_vc  out  1  VC of the granted flit (combinational).
- sel_q  out  SELW  registered crossbar select for the output data flop.
- ovalid_q  out  1  registered output valid.
- ovch_q  out  1  registered output VC.
- olck  out  NVC  VC v is currently locked to an input packet.

Behaviour:
- Reset is synchronous, active-high, one clock; there is no asynchronous path.
- Reset values: olck=0; all owners=0; rr_ptr=0; sel_q=0; ovalid_q=0; ovch_q=0.
- gnt=0 during any cycle with rst_=1.
- State per VC v: lck[v] (1 bit) and own[v] (SELW bits). Plus one shared round-robin pointer rr_ptr in 0..NPORT-1.
- Eligibility of input i, with v=req_vc[i]:
  - req[i]=1 and vc_rdy[v]=1, and
  - either lck[v]=0 and req_head[i]=1, or lck[v]=1 and own[v]=i.
- A non-head flit on an unlocked VC is never eligible (protocol error); it is held, not dropped.
- A head flit on a VC locked to another input waits.
- Grant: the first eligible input searching rr_ptr, rr_ptr+1, ... modulo NPORT. At most one gnt bit is set. gnt is combinational, granted the same cycle as the request.
- On a clock edge with a grant to input g on VC v:
  - rr_ptr <= (g+1) mod NPORT; wrap from 4 to 0.
  - Head and not tail: lck[v]<=1, own[v]<=g.
  - Tail (including head+tail): lck[v]<=0.
  - Body flit: lock unchanged.
- With no grant, rr_ptr and the locks hold.
- Output pipeline: latency 1.
  - sel_q <= g, ovalid_q <= 1, ovch_q <= v on a grant cycle.
  - Otherwise ovalid_q <= 0 while sel_q and ovch_q hold.
- Both VCs are independent: one VC may be mid-packet while the other VC's head flits arbitrate. The link still carries one flit per cycle.
- If vc_rdy[v] drops mid-packet, the lock persists and the owner simply waits.
- If rst_ is asserted mid-packet, all locks clear; the upstream is also reset, so no partial packet survives.
- olck = lck, registered.
- A grant on VC v with a tail in the same cycle leaves olck[v]=0 on the next cycle. A new head for v may win on that next cycle.

Decomposition:
- Shared router package holds: NPORT, NVC, SELW, port index constants (P_LOCAL=0, P_N..P_W=1..4), and a flit-type encoding for head/body/tail.
- One sub-module is natural: rtr_rr_arb, a generic NPORT-wide rotating-priority arbiter taking a request vector and pointer and returning a one-hot grant.
- rtr_out_port_arb holds the eligibility logic, VC lock state, and the output flops.

Test Plan:
- Reset: hold rst_=1 for 2 cycles with req=5'b11111 → gnt=0, olck=00, ovalid_q=0; release → first grant goes to input 0.
- Round-robin: inputs 1 and 3 send single-flit packets on VC0 repeatedly with vc_rdy=11 → grants alternate 1,3,1,3; sel_q follows one cycle later.
- Wormhole lock: input 2 sends head, body, body, tail on VC1 while input 4 sends a head on VC1 → input 4 is blocked until the tail is granted; olck[1]=1 for 3 cycles; input 4 is granted the next cycle.
- VC interleave: input 2 holds VC1 while input 0 sends a 2-flit packet on VC0 → grants alternate per round-robin across VCs; ovch_q tracks the granted VC.
- Backpressure: vc_rdy[0]=0 for 4 cycles mid-packet → no VC0 grants, lock held; resumes at the same owner once vc_rdy[0]=1.
- Mid-packet reset: assert rst_ after a head grant on VC0 → olck=00 and rr_ptr=0 next cycle; a stale body flit on VC0 receives no grant.

Source files
------------

// File: rtl/rtr_out_port_arb_pkg.sv
// Shared router constants, flit-type encoding and small helpers used by the
// output-port switch allocator.
package rtr_out_port_arb_pkg;

    localparam int NPORT = 5;   // input ports competing for one output
    localparam int NVC   = 2;   // virtual channels on the output link
    localparam int SELW  = 3;   // encoded crossbar select width, >= clog2(NPORT)

    // Port index constants of the 5-port mesh router.
    localparam int P_LOCAL = 0;
    localparam int P_N     = 1;
    localparam int P_E     = 2;
    localparam int P_S     = 3;
    localparam int P_W     = 4;

    // Flit type as {head, tail}; head+tail is a single-flit packet.
    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_TAIL   = 2'b01,
        FT_HEAD   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_t;

    function automatic flit_t flit_type(input logic head, input logic tail);
        return flit_t'({head, tail});
    endfunction

    // Round-robin pointer advance: one past the winner, wrapping to port 0.
    function automatic logic [SELW-1:0] rr_next(input logic [SELW-1:0] g);
        return (g == SELW'(NPORT - 1)) ? '0 : g + 1'b1;
    endfunction

endpackage

// File: rtl/rtr_out_port_arb_if.sv
// Request/grant bundle between the input ports and one output-port allocator.
// master: upstream side driving flit requests; slave: the allocator.
interface rtr_out_port_arb_if;
    import rtr_out_port_arb_pkg::*;

    logic [NPORT-1:0] req;
    logic [NPORT-1:0] req_vc;
    logic [NPORT-1:0] req_head;
    logic [NPORT-1:0] req_tail;
    logic [NVC-1:0]   vc_rdy;
    logic [NPORT-1:0] gnt;
    logic             gnt_vc;
    logic [SELW-1:0]  sel_q;
    logic             ovalid_q;
    logic             ovch_q;
    logic [NVC-1:0]   olck;

    modport master (
        output req, req_vc, req_head, req_tail, vc_rdy,
        input  gnt, gnt_vc, sel_q, ovalid_q, ovch_q, olck
    );

    modport slave (
        input  req, req_vc, req_head, req_tail, vc_rdy,
        output gnt, gnt_vc, sel_q, ovalid_q, ovch_q, olck
    );

endinterface

// File: rtl/rtr_rr_arb.sv
// Generic rotating-priority arbiter: the first set request found searching
// ptr, ptr+1, ... modulo N wins; the grant is one-hot or all zero.
module rtr_rr_arb
    import rtr_out_port_arb_pkg::*;
#(
    parameter int N  = NPORT,
    parameter int PW = SELW
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW-1:0] idx;
    logic          found;

    // Walk the request vector starting at the pointer, keep the first hit.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtr_out_port_arb.sv
// Per-output-port switch allocator: wormhole VC locking, per-VC downstream
// readiness, round-robin choice among eligible inputs, registered crossbar
// select / output valid / output VC, and upstream VC-lock status.
module rtr_out_port_arb
    import rtr_out_port_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_,
    rtr_out_port_arb_if.slave    bus
);

    logic [NVC-1:0]            lck_q, lck_d;
    logic [NVC-1:0][SELW-1:0]  own_q, own_d;
    logic [SELW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [SELW-1:0]           sel_q, sel_d;
    logic                      ovalid_q, ovalid_d;
    logic                      ovch_q, ovch_d;

    logic [NPORT-1:0]          elig;
    logic [NPORT-1:0]          arb_gnt;
    logic [NPORT-1:0]          gnt;
    logic                      gnt_any;
    logic [SELW-1:0]           gnt_idx;
    logic                      gnt_vc;
    flit_t                     gnt_ft;
    logic                      v;

    // Eligibility: VC ready, and either a head on a free VC or the VC's owner.
    // A body/tail flit on a free VC is never eligible and simply waits.
    always_comb begin
        elig = '0;
        v    = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            v = bus.req_vc[i];
            if (bus.req[i] && bus.vc_rdy[v]) begin
                if (lck_q[v]) begin
                    elig[i] = (own_q[v] == SELW'(i));
                end else begin
                    elig[i] = bus.req_head[i];
                end
            end
        end
    end

    rtr_rr_arb #(
        .N  (NPORT),
        .PW (SELW)
    ) u_rr_arb (
        .req (elig),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt)
    );

    // Suppress grants during reset and encode the winner, its VC and flit type.
    always_comb begin
        gnt     = rst_ ? '0 : arb_gnt;
        gnt_any = |gnt;
        gnt_idx = '0;
        gnt_vc  = 1'b0;
        gnt_ft  = FT_BODY;
        for (int i = 0; i < NPORT; i++) begin
            if (gnt[i]) begin
                gnt_idx = SELW'(i);
                gnt_vc  = bus.req_vc[i];
                gnt_ft  = flit_type(bus.req_head[i], bus.req_tail[i]);
            end
        end
    end

    // Next state: pointer advance, lock take/release, output pipeline stage.
    always_comb begin
        lck_d    = lck_q;
        own_d    = own_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        ovch_d   = ovch_q;
        ovalid_d = 1'b0;
        if (gnt_any) begin
            rr_ptr_d = rr_next(gnt_idx);
            sel_d    = gnt_idx;
            ovch_d   = gnt_vc;
            ovalid_d = 1'b1;
            case (gnt_ft)
                FT_HEAD: begin
                    lck_d[gnt_vc] = 1'b1;
                    own_d[gnt_vc] = gnt_idx;
                end
                FT_TAIL, FT_SINGLE: lck_d[gnt_vc] = 1'b0;
                default: ;
            endcase
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_) begin
            lck_q    <= '0;
            own_q    <= '0;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            ovalid_q <= 1'b0;
            ovch_q   <= 1'b0;
        end else begin
            lck_q    <= lck_d;
            own_q    <= own_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            ovalid_q <= ovalid_d;
            ovch_q   <= ovch_d;
        end
    end

    assign bus.gnt      = gnt;
    assign bus.gnt_vc   = gnt_vc;
    assign bus.sel_q    = sel_q;
    assign bus.ovalid_q = ovalid_q;
    assign bus.ovch_q   = ovch_q;
    assign bus.olck     = lck_q;

endmodule

// File: tb/tb_rtr_out_port_arb.sv
// Scoreboard bench for rtr_out_port_arb: directed per-cycle vectors push the
// hand-computed grant/lock expectations and the delayed output expectations;
// a monitor on the falling edge pops and compares.
module tb_rtr_out_port_arb;
    import rtr_out_port_arb_pkg::*;

    logic clk;
    logic rst_;

    rtr_out_port_arb_if bus ();

    rtr_out_port_arb dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NPORT-1:0] gnt;
        logic             vc;
        logic [NVC-1:0]   olck;
        logic [15:0]      id;
    } cyc_exp_t;

    typedef struct packed {
        logic [SELW-1:0] sel;
        logic            vc;
        logic [15:0]     id;
    } out_exp_t;

    cyc_exp_t exp_q[$];
    out_exp_t out_q[$];
    int       n_total = 0;
    int       n_pass  = 0;
    int       step_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
        n_total++;
        if (act !== req_val) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req_val);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [SELW-1:0] onehot_idx(input logic [NPORT-1:0] oh);
        logic [SELW-1:0] r;
        r = '0;
        for (int i = 0; i < NPORT; i++) if (oh[i]) r = SELW'(i);
        return r;
    endfunction

    // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic rst, input logic [4:0] rq, input logic [4:0] vc,
                        input logic [4:0] hd, input logic [4:0] tl, input logic [1:0] rdy,
                        input logic [4:0] eg, input logic [1:0] eolck);
        cyc_exp_t c;
        out_exp_t o;
        rst_         = rst;
        bus.req      = rq;
        bus.req_vc   = vc;
        bus.req_head = hd;
        bus.req_tail = tl;
        bus.vc_rdy   = rdy;
        c.gnt  = eg;
        c.vc   = |(eg & vc);
        c.olck = eolck;
        c.id   = 16'(step_id);
        exp_q.push_back(c);
        if (eg != '0) begin
            o.sel = onehot_idx(eg);
            o.vc  = |(eg & vc);
            o.id  = 16'(step_id);
            out_q.push_back(o);
        end
        step_id++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares combinational grant and lock state every cycle, and
    // the registered output stage whenever it presents a valid flit.
    initial begin
        cyc_exp_t c;
        out_exp_t o;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                c = exp_q.pop_front();
                check($sformatf("gnt@%0d", c.id), 32'(bus.gnt), 32'(c.gnt));
                if (c.gnt != '0) check($sformatf("gnt_vc@%0d", c.id), 32'(bus.gnt_vc), 32'(c.vc));
                check($sformatf("olck@%0d", c.id), 32'(bus.olck), 32'(c.olck));
            end
            if (bus.ovalid_q !== 1'b0) begin
                if (out_q.size() == 0) begin
                    check("spurious_ovalid", 32'(bus.ovalid_q), 32'd0);
                end else begin
                    o = out_q.pop_front();
                    check($sformatf("ovalid@%0d", o.id), 32'(bus.ovalid_q), 32'd1);
                    check($sformatf("sel_q@%0d", o.id), 32'(bus.sel_q), 32'(o.sel));
                    check($sformatf("ovch_q@%0d", o.id), 32'(bus.ovch_q), 32'(o.vc));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_         = 1'b1;
        bus.req      = '0;
        bus.req_vc   = '0;
        bus.req_head = '0;
        bus.req_tail = '0;
        bus.vc_rdy   = 2'b11;
        @(posedge clk);
        #1;

        // Reset held two cycles with every input requesting: no grants.
        step(1, 5'b11111, 5'b00000, 5'b11111, 5'b11111, 2'b11, 5'b00000, 2'b00);
        step(1, 5'b11111, 5'b00000, 5'b11111, 5'b11111, 2'b11, 5'b00000, 2'b00);
        check("rst_sel_q",    32'(bus.sel_q),    32'd0);
        check("rst_ovch_q",   32'(bus.ovch_q),   32'd0);
        check("rst_ovalid_q", 32'(bus.ovalid_q), 32'd0);
        // Release: pointer at 0, input 0 wins.
        step(0, 5'b11111, 5'b00000, 5'b11111, 5'b11111, 2'b11, 5'b00001, 2'b00);

        // Round-robin between inputs 1 and 3 (single-flit, VC0).
        for (int k = 0; k < 4; k++) begin
            step(0, 5'b01010, 5'b00000, 5'b01010, 5'b01010, 2'b11,
                 (k % 2 == 0) ? 5'b00010 : 5'b01000, 2'b00);
        end
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b11, 5'b00000, 2'b00);

        // Wormhole: input 2 owns VC1 head..tail; input 4's head on VC1 waits.
        step(0, 5'b00100, 5'b00100, 5'b00100, 5'b00000, 2'b11, 5'b00100, 2'b00);
        step(0, 5'b10100, 5'b10100, 5'b10000, 5'b10000, 2'b11, 5'b00100, 2'b10);
        step(0, 5'b10100, 5'b10100, 5'b10000, 5'b10000, 2'b11, 5'b00100, 2'b10);
        step(0, 5'b10100, 5'b10100, 5'b10000, 5'b10100, 2'b11, 5'b00100, 2'b10);
        step(0, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 2'b11, 5'b10000, 2'b00);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b11, 5'b00000, 2'b00);

        // VC interleave: input 0 two-flit on VC0, input 2 two-flit on VC1.
        step(0, 5'b00101, 5'b00100, 5'b00101, 5'b00000, 2'b11, 5'b00001, 2'b00);
        step(0, 5'b00101, 5'b00100, 5'b00100, 5'b00001, 2'b11, 5'b00100, 2'b01);
        step(0, 5'b00101, 5'b00100, 5'b00000, 5'b00001, 2'b11, 5'b00001, 2'b11);
        step(0, 5'b00100, 5'b00100, 5'b00000, 5'b00100, 2'b11, 5'b00100, 2'b10);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b11, 5'b00000, 2'b00);

        // Backpressure: input 1 owns VC0, vc_rdy[0] low 4 cycles, input 4 waits.
        step(0, 5'b00010, 5'b00000, 5'b00010, 5'b00000, 2'b11, 5'b00010, 2'b00);
        for (int k = 0; k < 4; k++) begin
            step(0, 5'b10010, 5'b00000, 5'b10000, 5'b10000, 2'b10, 5'b00000, 2'b01);
        end
        step(0, 5'b10010, 5'b00000, 5'b10000, 5'b10000, 2'b11, 5'b00010, 2'b01);
        step(0, 5'b10010, 5'b00000, 5'b10000, 5'b10010, 2'b11, 5'b00010, 2'b01);
        step(0, 5'b10000, 5'b00000, 5'b10000, 5'b10000, 2'b11, 5'b10000, 2'b00);

        // Mid-packet reset: head from input 3 on VC0, then reset, then stale body.
        step(0, 5'b01000, 5'b00000, 5'b01000, 5'b00000, 2'b11, 5'b01000, 2'b00);
        step(1, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 2'b11, 5'b00000, 2'b01);
        step(0, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 2'b11, 5'b00000, 2'b00);
        check("mrst_sel_q",  32'(bus.sel_q),  32'd0);
        check("mrst_ovch_q", 32'(bus.ovch_q), 32'd0);
        // Pointer back at 0: input 0 beats input 4; stale body still held.
        step(0, 5'b11001, 5'b00000, 5'b10001, 5'b10001, 2'b11, 5'b00001, 2'b00);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b11, 5'b00000, 2'b00);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b11, 5'b00000, 2'b00);

        @(negedge clk);
        check("out_q_drained", 32'(out_q.size()), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
